// File: rtl/clk_div_multi.sv
// clk_div_multi
// Multi-channel programmable clock/tick generator for the rover timing tree.
// Each channel runs a period counter on the system clock and produces a
// registered divided clock plus a one-cycle tick on the last cycle of every
// period. Period and high time are written into pending registers and only
// copied into the active registers at a period boundary (or while the channel
// is idle), so a live output never shows a runt pulse.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   en           per-channel run enable
//   sync         synchronous global phase clear for every channel
//   cfg_we       config write strobe, one write per cycle
//   cfg_ch       target channel of the write (out-of-range writes are dropped)
//   cfg_sel      0 = period register, 1 = high-time register
//   cfg_data     value written
//   clk_out      divided clocks, registered
//   tick         one-cycle strobe on the last cycle of each period
//   cfg_pending  a written config is waiting for its period boundary
module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(50000000),
  parameter logic [CNT_W-1:0] DEF_HIGH = CNT_W'(25000000),
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [CNT_W-1:0] act_p  [NUM_CH];
  logic [CNT_W-1:0] act_h  [NUM_CH];
  logic [CNT_W-1:0] pend_p [NUM_CH];
  logic [CNT_W-1:0] pend_h [NUM_CH];
  logic [NUM_CH-1:0] pflag;

  logic [NUM_CH-1:0] halt;
  logic [NUM_CH-1:0] at_end;
  logic [NUM_CH-1:0] wr_hit;

  // A channel is idle when disabled, globally synced, or programmed with a
  // zero period. Idle channels hold cnt at 0 and may take pending config on
  // any edge. cfg_ch values at or above NUM_CH never match a channel index,
  // which is what drops out-of-range writes.
  always_comb begin
    halt   = '0;
    at_end = '0;
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      halt[c]   = !en[c] || sync || (act_p[c] == '0);
      at_end[c] = (cnt[c] == act_p[c] - CNT_W'(1));
      wr_hit[c] = cfg_we && (cfg_ch == CH_W'(c));
    end
  end

  assign cfg_pending = pflag;

  // Per-channel counter, outputs and config registers. The apply copies the
  // pending contents as they were before this edge; a write landing on the
  // same edge is assigned afterwards, so it wins pflag and waits for the
  // next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c]    <= '0;
        act_p[c]  <= DEF_PERIOD;
        act_h[c]  <= DEF_HIGH;
        pend_p[c] <= DEF_PERIOD;
        pend_h[c] <= DEF_HIGH;
      end
      pflag   <= '0;
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (halt[c]) begin
          cnt[c]     <= '0;
          clk_out[c] <= 1'b0;
          tick[c]    <= 1'b0;
        end else begin
          clk_out[c] <= (cnt[c] < act_h[c]);
          tick[c]    <= at_end[c];
          cnt[c]     <= at_end[c] ? '0 : cnt[c] + CNT_W'(1);
        end

        if ((halt[c] || at_end[c]) && pflag[c]) begin
          act_p[c] <= pend_p[c];
          act_h[c] <= pend_h[c];
          pflag[c] <= 1'b0;
        end

        if (wr_hit[c]) begin
          if (cfg_sel) begin
            pend_h[c] <= cfg_data;
          end else begin
            pend_p[c] <= cfg_data;
          end
          pflag[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with three channels, an 8-bit counter and
// a 6-cycle / 3-high reset configuration so whole periods fit in a few steps.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_clk_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W = 8;
  localparam int CH_W = 2;

  logic              clk;
  logic              clk_run;
  logic              rst_n;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic              cfg_sel;
  logic [CNT_W-1:0]  cfg_data;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  int checks;
  int errors;

  clk_div_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEF_PERIOD(8'd6),
    .DEF_HIGH(8'd3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .sync(sync),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel),
    .cfg_data(cfg_data),
    .clk_out(clk_out),
    .tick(tick),
    .cfg_pending(cfg_pending)
  );

  // Free-running 10 ns clock that can be parked low for the async reset test.
  initial begin
    clk = 1'b0;
    clk_run = 1'b1;
  end

  always begin
    #5;
    if (clk_run) clk = ~clk;
    else clk = 1'b0;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reset holds everything low, then the default 111000 pattern on every channel.
  task automatic test_reset;
    logic [11:0] exp_clk;
    logic [11:0] exp_tick;
    exp_clk = 12'b111000111000;
    exp_tick = 12'b000001000001;
    rst_n = 1'b0; en = 3'b111; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
    step; step;
    checks++;
    if (clk_out !== 3'b000) begin errors++; $display("[TB] FAIL reset_clk_out got %b expected 000", clk_out); end
    checks++;
    if (tick !== 3'b000) begin errors++; $display("[TB] FAIL reset_tick got %b expected 000", tick); end
    checks++;
    if (cfg_pending !== 3'b000) begin errors++; $display("[TB] FAIL reset_pending got %b expected 000", cfg_pending); end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step;
      checks++;
      if (clk_out !== {3{exp_clk[11-i]}}) begin
        errors++; $display("[TB] FAIL default_clk step %0d got %b expected %b", i, clk_out, {3{exp_clk[11-i]}});
      end
      checks++;
      if (tick !== {3{exp_tick[11-i]}}) begin
        errors++; $display("[TB] FAIL default_tick step %0d got %b expected %b", i, tick, {3{exp_tick[11-i]}});
      end
    end
  endtask

  // ch0 gets P=5 H=2 at the start of a period; it takes effect after that period.
  task automatic test_odd_period;
    logic [15:0] c0, t0, c1, t1, p0;
    c0 = 16'b1110001100011000;
    t0 = 16'b0000010000100001;
    c1 = 16'b1110001110001110;
    t1 = 16'b0000010000010000;
    p0 = 16'b1111100000000000;
    for (int i = 0; i < 16; i++) begin
      cfg_we = (i < 2); cfg_ch = 2'd0; cfg_sel = (i == 1);
      cfg_data = (i == 0) ? 8'd5 : 8'd2;
      step;
      checks++;
      if (clk_out !== {c1[15-i], c1[15-i], c0[15-i]}) begin
        errors++; $display("[TB] FAIL odd_clk step %0d got %b expected %b", i, clk_out, {c1[15-i], c1[15-i], c0[15-i]});
      end
      checks++;
      if (tick !== {t1[15-i], t1[15-i], t0[15-i]}) begin
        errors++; $display("[TB] FAIL odd_tick step %0d got %b expected %b", i, tick, {t1[15-i], t1[15-i], t0[15-i]});
      end
      checks++;
      if (cfg_pending !== {2'b00, p0[15-i]}) begin
        errors++; $display("[TB] FAIL odd_pending step %0d got %b expected %b", i, cfg_pending, {2'b00, p0[15-i]});
      end
    end
    cfg_we = 1'b0;
  endtask

  // ch0 at cnt=2 receives P=4 H=1; the running 5-cycle period finishes first.
  task automatic test_mid_period;
    logic [12:0] c0, t0, c1, t1, p0;
    c0 = 13'b1100010001000;
    t0 = 13'b0000100010001;
    c1 = 13'b0011100011100;
    t1 = 13'b0100000100000;
    p0 = 13'b0011000000000;
    for (int i = 0; i < 13; i++) begin
      cfg_we = (i == 2) || (i == 3); cfg_ch = 2'd0; cfg_sel = (i == 3);
      cfg_data = (i == 2) ? 8'd4 : 8'd1;
      step;
      checks++;
      if (clk_out !== {c1[12-i], c1[12-i], c0[12-i]}) begin
        errors++; $display("[TB] FAIL mid_clk step %0d got %b expected %b", i, clk_out, {c1[12-i], c1[12-i], c0[12-i]});
      end
      checks++;
      if (tick !== {t1[12-i], t1[12-i], t0[12-i]}) begin
        errors++; $display("[TB] FAIL mid_tick step %0d got %b expected %b", i, tick, {t1[12-i], t1[12-i], t0[12-i]});
      end
      checks++;
      if (cfg_pending !== {2'b00, p0[12-i]}) begin
        errors++; $display("[TB] FAIL mid_pending step %0d got %b expected %b", i, cfg_pending, {2'b00, p0[12-i]});
      end
    end
    cfg_we = 1'b0;
  endtask

  // Degenerate settings on ch2: H=0, H>P, P=0 halt, then P=1 H=1.
  task automatic test_degenerate;
    logic [7:0] tz, tf;
    logic [12:0] c2, t2, p2;
    tz = 8'b00000100;
    tf = 8'b00010001;
    c2 = 13'b1111000011111;
    t2 = 13'b0001000011111;
    p2 = 13'b1110001010000;

    en = 3'b011;
    step;
    checks++;
    if (tick[2] !== 1'b0 || clk_out[2] !== 1'b0) begin
      errors++; $display("[TB] FAIL disable_ch2 got clk %b tick %b expected 0 0", clk_out[2], tick[2]);
    end
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 1'b1; cfg_data = 8'd0;
    step;
    cfg_we = 1'b0;
    checks++;
    if (cfg_pending[2] !== 1'b1) begin errors++; $display("[TB] FAIL h0_pending_set got %b expected 1", cfg_pending[2]); end
    step;
    checks++;
    if (cfg_pending[2] !== 1'b0) begin errors++; $display("[TB] FAIL h0_pending_apply got %b expected 0", cfg_pending[2]); end
    en = 3'b111;
    for (int i = 0; i < 8; i++) begin
      step;
      checks++;
      if (clk_out[2] !== 1'b0 || tick[2] !== tz[7-i]) begin
        errors++; $display("[TB] FAIL h0_out step %0d got clk %b tick %b expected 0 %b", i, clk_out[2], tick[2], tz[7-i]);
      end
    end

    en = 3'b011;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sel = 1'b0; cfg_data = 8'd4;
    step;
    cfg_sel = 1'b1; cfg_data = 8'd9;
    step;
    cfg_we = 1'b0;
    step;
    checks++;
    if (cfg_pending[2] !== 1'b0) begin errors++; $display("[TB] FAIL h9_pending_apply got %b expected 0", cfg_pending[2]); end
    en = 3'b111;
    for (int i = 0; i < 8; i++) begin
      step;
      checks++;
      if (clk_out[2] !== 1'b1 || tick[2] !== tf[7-i]) begin
        errors++; $display("[TB] FAIL h9_out step %0d got clk %b tick %b expected 1 %b", i, clk_out[2], tick[2], tf[7-i]);
      end
    end

    for (int i = 0; i < 13; i++) begin
      cfg_we = (i == 0) || (i == 6) || (i == 8); cfg_ch = 2'd2; cfg_sel = (i == 8);
      cfg_data = (i == 0) ? 8'd0 : 8'd1;
      step;
      checks++;
      if (clk_out[2] !== c2[12-i] || tick[2] !== t2[12-i]) begin
        errors++; $display("[TB] FAIL p0p1_out step %0d got clk %b tick %b expected %b %b", i, clk_out[2], tick[2], c2[12-i], t2[12-i]);
      end
      checks++;
      if (cfg_pending[2] !== p2[12-i]) begin
        errors++; $display("[TB] FAIL p0p1_pending step %0d got %b expected %b", i, cfg_pending[2], p2[12-i]);
      end
    end
    cfg_we = 1'b0;
  endtask

  // Sync realigns channels offset by 3 cycles; dropping en[1] idles only ch1.
  task automatic test_sync_enable;
    logic [21:0] c0, t0, c1, t1;
    logic exp2;
    c0 = 22'b0001110001110111000111;
    t0 = 22'b0000000010000000001000;
    c1 = 22'b0000001110000111000000;
    t1 = 22'b0000000000010000001000;
    for (int i = 0; i < 22; i++) begin
      cfg_we = (i < 2); cfg_ch = 2'd0; cfg_sel = (i == 1);
      cfg_data = (i == 0) ? 8'd6 : 8'd3;
      sync = (i == 2) || (i == 12);
      if ((i >= 3 && i <= 5) || i >= 19) en = 3'b101;
      else en = 3'b111;
      step;
      if (i >= 2) begin
        exp2 = !((i == 2) || (i == 12));
        checks++;
        if (clk_out !== {exp2, c1[21-i], c0[21-i]}) begin
          errors++; $display("[TB] FAIL sync_clk step %0d got %b expected %b", i, clk_out, {exp2, c1[21-i], c0[21-i]});
        end
        checks++;
        if (tick !== {exp2, t1[21-i], t0[21-i]}) begin
          errors++; $display("[TB] FAIL sync_tick step %0d got %b expected %b", i, tick, {exp2, t1[21-i], t0[21-i]});
        end
        checks++;
        if (cfg_pending !== 3'b000) begin
          errors++; $display("[TB] FAIL sync_pending step %0d got %b expected 000", i, cfg_pending);
        end
      end
    end
    cfg_we = 1'b0;
    sync = 1'b0;
  endtask

  // Out-of-range write is dropped; async reset with the clock parked clears
  // outputs and pending, and defaults return after release.
  task automatic test_async_reset;
    logic [5:0] exp_clk;
    logic [5:0] exp_tick;
    exp_clk = 6'b111000;
    exp_tick = 6'b000001;
    en = 3'b111;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_sel = 1'b0; cfg_data = 8'd2;
    step;
    checks++;
    if (cfg_pending !== 3'b000) begin errors++; $display("[TB] FAIL oob_write got %b expected 000", cfg_pending); end
    cfg_ch = 2'd1;
    step;
    cfg_we = 1'b0;
    checks++;
    if (cfg_pending !== 3'b010) begin errors++; $display("[TB] FAIL ch1_write got %b expected 010", cfg_pending); end
    checks++;
    if (clk_out[2] !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_ch2 got %b expected 1", clk_out[2]); end

    clk_run = 1'b0;
    #20;
    rst_n = 1'b0;
    #2;
    checks++;
    if (clk_out !== 3'b000) begin errors++; $display("[TB] FAIL async_clk_out got %b expected 000", clk_out); end
    checks++;
    if (tick !== 3'b000) begin errors++; $display("[TB] FAIL async_tick got %b expected 000", tick); end
    checks++;
    if (cfg_pending !== 3'b000) begin errors++; $display("[TB] FAIL async_pending got %b expected 000", cfg_pending); end
    #5;
    rst_n = 1'b1;
    #5;
    clk_run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step;
      checks++;
      if (clk_out !== {3{exp_clk[5-(i%6)]}} || tick !== {3{exp_tick[5-(i%6)]}}) begin
        errors++; $display("[TB] FAIL post_reset step %0d got clk %b tick %b expected %b %b", i, clk_out, tick,
                           {3{exp_clk[5-(i%6)]}}, {3{exp_tick[5-(i%6)]}});
      end
      checks++;
      if (cfg_pending !== 3'b000) begin
        errors++; $display("[TB] FAIL post_reset_pending step %0d got %b expected 000", i, cfg_pending);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] clk_div_multi directed test start");
    test_reset;
    test_odd_period;
    test_mid_period;
    test_degenerate;
    test_sync_enable;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock/tick generator for the rover's timing tree.
- NUM_CH independent channels, each a period counter clocked by the system clock.
- Each channel drives a registered, glitch-free divided clock with a programmable high time, plus a one-cycle tick strobe per period.
- Period and high time are runtime-configurable through a write port. New values take effect only at a period boundary, so live outputs never produce a runt pulse.
- Per-channel enables and a global sync phase-align channels. Consumers are motor PWM timebases, sensor poll strobes and the 1 Hz status blink.

## Interface
Parameters
- NUM_CH, 4, number of channels (≥1)
- CNT_W, 32, counter/period/high-time width
- DEF_PERIOD, 50000000, reset period in clk cycles (1 Hz at 50 MHz)
- DEF_HIGH, 25000000, reset high time in clk cycles

Ports
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  NUM_CH  per-channel run enable
- sync  in  1  synchronous global phase clear
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_ch  in  max(1,clog2(NUM_CH))  target channel
- cfg_sel  in  1  0 = period register, 1 = high-time register
- cfg_data  in  CNT_W  value written
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle strobe, last cycle of each period
- cfg_pending  out  NUM_CH  pending config not yet applied

## Operation
Per-channel state
- cnt: counter.
- act_p, act_h: active period and high time.
- pend_p, pend_h: pending period and high time.
- pflag: pending flag, drives cfg_pending.

Reset, asynchronous
- cnt = 0.
- act_p = pend_p = DEF_PERIOD; act_h = pend_h = DEF_HIGH.
- pflag = 0, clk_out = 0, tick = 0.

Config writes
- cfg_we with cfg_ch < NUM_CH: cfg_data goes to pend_p or pend_h; pflag set.
- cfg_ch ≥ NUM_CH: write ignored.
- Active registers are never written directly.

Count and outputs, per edge, channel enabled, sync low, act_p ≥ 1
- clk_out <= (cnt < act_h).
- tick <= (cnt == act_p−1).
- If cnt == act_p−1 (boundary): cnt <= 0; if pflag, act <= pend and pflag <= 0. Otherwise cnt <= cnt+1.

Edge cases
- act_h = 0: clk_out constant 0.
- act_h ≥ act_p: clk_out constant 1.
- act_p = 1: cnt stays 0; tick constantly 1; clk_out = (act_h ≥ 1).
- act_p = 0: channel halted. cnt held 0, clk_out = 0, tick = 0. Pending applied on the next edge if pflag is set.
- en low: cnt <= 0, clk_out <= 0, tick <= 0. Pending applied immediately if pflag is set.
- On re-enable, counting starts from cnt = 0.

Sync
- sync high: on every channel, cnt <= 0, clk_out <= 0, tick <= 0.
- Pending values are applied as at a boundary.
- en low and sync give the same result; no conflict.

Simultaneous write and apply on one edge
- The apply uses the pending contents from before the edge.
- The new write lands in pending, and pflag stays 1 for the next boundary.
- Writing the same field twice before a boundary: last value wins.

Arithmetic
- All compares are unsigned CNT_W.
- cnt never exceeds act_p−1, so no wrap beyond the period.

## Timing
- Outputs lag cnt by one cycle: registered, no combinational path from any input to any output.
- Enabled channel: clk_out has a period of exactly act_p cycles and is high for min(act_h, act_p) cycles.
- First high cycle appears 1 edge after en rises, sync falls, or rst_n deasserts with en already high.
- tick coincides with the last clk_out cycle of each period.
- Config latency: a write in period k affects outputs from the first cycle of period k+1. If the write lands on the boundary edge, it affects period k+2.
- cfg_pending rises the edge after the write and falls on the applying edge.
- rst_n assertion mid-period forces all outputs low immediately, with no clock needed.

## Test plan
- Reset defaults: NUM_CH=2, DEF_PERIOD=6, DEF_HIGH=3, en=11 -> both clk_out 111000 repeating; tick high on every 6th cycle; cfg_pending=00.
- Odd period: write ch0 P=5, H=2 -> after next boundary, clk_out[0] = 11000 repeating; tick[0] every 5 cycles; ch1 unaffected.
- Mid-period reconfig: ch0 at cnt=2, write P=4, H=1 -> current 6-cycle period completes unchanged, then 1000 repeating; cfg_pending[0] high from the write edge+1 through the boundary edge.
- Degenerate values: H=0 -> constant 0; H=9 with P=4 -> constant 1; P=0 -> outputs 0 with cfg_pending cleared next edge; P=1, H=1 -> clk_out and tick constantly 1.
- Sync/enable: ch0 and ch1 offset by 3 cycles, pulse sync 1 cycle -> outputs 0 for that cycle, then identical phase. Drop en[1] -> ch1 outputs 0 next edge, ch0 continues.
- Async reset: assert rst_n low mid-period with clk stopped -> clk_out, tick, cfg_pending go 0 immediately; after release, defaults restored.
